// File: rtl/mcp_neuron_node_if.sv
// Signal bundle for the two-input McCulloch-Pitts neuron node.
// master drives en/x/y/inh/Threshold; slave returns fire/sum/valid.
interface mcp_neuron_node_if;
    logic       en;
    logic       x;
    logic       y;
    logic       inh;
    logic [1:0] Threshold;
    logic       fire;
    logic [1:0] sum;
    logic       valid;

    modport master (
        output en,
        output x,
        output y,
        output inh,
        output Threshold,
        input  fire,
        input  sum,
        input  valid
    );

    modport slave (
        input  en,
        input  x,
        input  y,
        input  inh,
        input  Threshold,
        output fire,
        output sum,
        output valid
    );
endinterface

// File: rtl/mcp_neuron_node.sv
// Two-input McCulloch-Pitts threshold neuron with registered fire/sum/valid.
// Ports: clk, rst (sync, active-high), bus (slave: en,x,y,inh,Threshold -> fire,sum,valid).
module mcp_neuron_node (
    input  logic               clk,
    input  logic               rst,
    mcp_neuron_node_if.slave   bus
);

    logic [1:0] s;
    logic       hit;
    logic       fire_next;

    logic       fire_d;
    logic       fire_q;
    logic [1:0] sum_d;
    logic [1:0] sum_q;
    logic       valid_d;
    logic       valid_q;

    // Sum is at most 2, so the 2-bit zero-extended add never overflows.
    // Threshold 3 therefore never fires.
    always_comb begin
        s         = {1'b0, bus.x} + {1'b0, bus.y};
        hit       = (s >= bus.Threshold);
        fire_next = hit & ~bus.inh;
    end

    // Hold state when not enabled so X/Z on idle inputs cannot leak in.
    always_comb begin
        fire_d  = fire_q;
        sum_d   = sum_q;
        valid_d = 1'b0;
        if (bus.en) begin
            fire_d  = fire_next;
            sum_d   = s;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fire_q  <= 1'b0;
            sum_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            fire_q  <= fire_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
        end
    end

    assign bus.fire  = fire_q;
    assign bus.sum   = sum_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_mcp_neuron_node.sv
// Scoreboard bench for mcp_neuron_node.
// Directed vectors push expected outputs; a monitor pops and checks them.
module tb_mcp_neuron_node;

    typedef struct {
        logic       fire;
        logic [1:0] sum;
        logic       valid;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb_q[$];

    mcp_neuron_node_if bus ();

    mcp_neuron_node dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [1:0] act,
                       input logic [1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, req);
        end
    endtask

    // Entries pushed before an edge were sampled at that edge; check on
    // the following falling edge.
    initial begin
        int   n;
        exp_t e;
        forever begin
            @(posedge clk);
            n = sb_q.size();
            @(negedge clk);
            if (n > 0) begin
                e = sb_q.pop_front();
                chk({e.name, ".valid"}, {1'b0, bus.valid}, {1'b0, e.valid});
                chk({e.name, ".fire"},  {1'b0, bus.fire},  {1'b0, e.fire});
                chk({e.name, ".sum"},   bus.sum,           e.sum);
            end
        end
    end

    // Drive one vector for the next edge and push its hand-computed result.
    task automatic apply(input string nm, input logic r, input logic e,
                         input logic xi, input logic yi, input logic ih,
                         input logic [1:0] th, input logic ef,
                         input logic [1:0] es, input logic ev);
        exp_t x_e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.en        = e;
        bus.x         = xi;
        bus.y         = yi;
        bus.inh       = ih;
        bus.Threshold = th;
        x_e.fire  = ef;
        x_e.sum   = es;
        x_e.valid = ev;
        x_e.name  = nm;
        sb_q.push_back(x_e);
    endtask

    initial begin
        int waited;
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.x         = 1'b0;
        bus.y         = 1'b0;
        bus.inh       = 1'b0;
        bus.Threshold = 2'd0;

        //     name       rst en x y inh th  fire sum valid
        apply("reset0",   1, 0, 0, 0, 0, 0,  0, 0, 0);
        apply("reset_en", 1, 1, 1, 1, 0, 0,  0, 0, 0);
        apply("and00",    0, 1, 0, 0, 0, 2,  0, 0, 1);
        apply("and01",    0, 1, 0, 1, 0, 2,  0, 1, 1);
        apply("and10",    0, 1, 1, 0, 0, 2,  0, 1, 1);
        apply("and11",    0, 1, 1, 1, 0, 2,  1, 2, 1);
        apply("or00",     0, 1, 0, 0, 0, 1,  0, 0, 1);
        apply("or01",     0, 1, 0, 1, 0, 1,  1, 1, 1);
        apply("or10",     0, 1, 1, 0, 0, 1,  1, 1, 1);
        apply("or11",     0, 1, 1, 1, 0, 1,  1, 2, 1);
        apply("th0_00",   0, 1, 0, 0, 0, 0,  1, 0, 1);
        apply("th3_11",   0, 1, 1, 1, 0, 3,  0, 2, 1);
        apply("inh_on",   0, 1, 1, 1, 1, 1,  0, 2, 1);
        apply("inh_off",  0, 1, 1, 1, 0, 1,  1, 2, 1);
        apply("th2_10",   0, 1, 1, 0, 0, 2,  0, 1, 1);
        apply("th1_10",   0, 1, 1, 0, 0, 1,  1, 1, 1);
        apply("hold_set", 0, 1, 1, 1, 0, 2,  1, 2, 1);
        apply("hold1",    0, 0, 0, 0, 0, 2,  1, 2, 0);
        apply("hold2",    0, 0, 0, 0, 1, 3,  1, 2, 0);
        apply("hold3",    0, 0, 0, 0, 0, 0,  1, 2, 0);
        apply("rst_mid",  1, 1, 1, 1, 0, 2,  0, 0, 0);
        apply("post_idle",0, 0, 1, 1, 0, 2,  0, 0, 0);
        apply("post_ev",  0, 1, 0, 1, 0, 1,  1, 1, 1);
        apply("post_hold",0, 0, 0, 0, 0, 3,  1, 1, 0);

        @(posedge clk);
        #1;
        bus.en = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: left=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
